// File: rtl/alu_pkg.sv
// Shared definitions for the multi-byte ALU sequencer.
//   - ALU opcode constants understood by the team's 8-bit ALU
//   - sequencer FSM state encoding
//   - helper telling whether an opcode chains carry between bytes
package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Only add/subtract propagate carry from one byte into the next.
   function automatic logic is_arith(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_multibyte_sequencer.sv
// alu_multibyte_sequencer
//   Accepts one W-bit command (W = 8*NBYTES) and walks it through an
//   external 8-bit ALU one byte per cycle, LSB first, chaining carry for
//   arithmetic ops. The assembled result and last-byte flags are held on a
//   valid/ready response port until consumed.
//
//   State table
//   state | meaning
//   IDLE  | cmd_ready high, waiting for a command
//   EXEC  | driving byte idx to the ALU, capturing its result
//   DONE  | response valid, held until rsp_ready
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_a, cmd_b [W]               operands
//   cmd_op [4], cmd_cin            opcode, byte-0 carry-in
//   alu_a, alu_b [8], alu_op [4], alu_cin      to the ALU
//   alu_result [8], alu_cout, alu_negative, alu_overflow   from the ALU
//   rsp_valid/rsp_ready            response handshake
//   rsp_result [W], rsp_cout, rsp_zero, rsp_negative, rsp_overflow
module alu_multibyte_sequencer
   import alu_pkg::*;
#(
   parameter int NBYTES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,

   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [8*NBYTES-1:0]   cmd_a,
   input  logic [8*NBYTES-1:0]   cmd_b,
   input  logic [3:0]            cmd_op,
   input  logic                  cmd_cin,

   output logic [7:0]            alu_a,
   output logic [7:0]            alu_b,
   output logic [3:0]            alu_op,
   output logic                  alu_cin,
   input  logic [7:0]            alu_result,
   input  logic                  alu_cout,
   input  logic                  alu_negative,
   input  logic                  alu_overflow,

   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [8*NBYTES-1:0]   rsp_result,
   output logic                  rsp_cout,
   output logic                  rsp_zero,
   output logic                  rsp_negative,
   output logic                  rsp_overflow
);

   localparam int W    = 8 * NBYTES;
   localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

   state_t            state_q, state_d;
   logic [IDXW-1:0]   idx_q;
   logic [W-1:0]      a_q, b_q;
   logic [3:0]        op_q;
   logic              cin_q;
   logic              carry_q;
   logic [W-1:0]      result_q;
   logic              cout_q, zero_q, neg_q, ovf_q;

   logic              last_byte;
   logic [W-1:0]      result_next;

   assign last_byte = (idx_q == LAST_IDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cmd_ready   = 1'b0;
      rsp_valid   = 1'b0;
      alu_a       = 8'h00;
      alu_b       = 8'h00;
      alu_op      = 4'h0;
      alu_cin     = 1'b0;
      result_next = result_q;
      result_next[8*idx_q +: 8] = alu_result;

      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            alu_a  = a_q[8*idx_q +: 8];
            alu_b  = b_q[8*idx_q +: 8];
            alu_op = op_q;
            // Logic ops never see a carry, even if the command supplied one.
            if (is_arith(op_q)) begin
               alu_cin = (idx_q == '0) ? cin_q : carry_q;
            end
            if (last_byte) begin
               state_d = DONE;
            end
         end
         DONE: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= 4'h0;
         cin_q    <= 1'b0;
         carry_q  <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
         zero_q   <= 1'b0;
         neg_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  a_q   <= cmd_a;
                  b_q   <= cmd_b;
                  op_q  <= cmd_op;
                  cin_q <= cmd_cin;
                  idx_q <= '0;
               end
            end
            EXEC: begin
               result_q <= result_next;
               carry_q  <= alu_cout;
               if (last_byte) begin
                  cout_q <= alu_cout;
                  neg_q  <= alu_negative;
                  ovf_q  <= alu_overflow;
                  // Zero is judged on the whole word, not the ALU's byte flag.
                  zero_q <= (result_next == '0);
               end else begin
                  idx_q <= idx_q + IDXW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign rsp_result   = result_q;
   assign rsp_cout     = cout_q;
   assign rsp_zero     = zero_q;
   assign rsp_negative = neg_q;
   assign rsp_overflow = ovf_q;

endmodule
